// File: rtl/scoreboard_display.sv
// scoreboard_display
//   Counting and display end of the scoreboard path. Applies single-cycle
//   inc/dec/erase pulses to a wrap-around BCD score and drives a
//   time-multiplexed seven-segment display with leading-zero blanking.
//
// Parameters
//   DIGITS   : number of BCD digits (1..4)
//   SCAN_DIV : clock cycles each digit stays enabled (>= 1)
//
// Ports
//   clk      : clock, rising-edge
//   rst      : asynchronous active-low reset
//   inc_i    : increment pulse
//   dec_i    : decrement pulse
//   erase_i  : clear-score pulse (highest priority)
//   score_o  : BCD score, digit k in bits [4k+3:4k]
//   wrap_o   : one-cycle pulse on wrap in either direction
//   an_o     : one-hot digit enable, active-high
//   seg_o    : segments {g,f,e,d,c,b,a}, active-high
module scoreboard_display #(
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_i,
  input  logic                  dec_i,
  input  logic                  erase_i,
  output logic [4*DIGITS-1:0]   score_o,
  output logic                  wrap_o,
  output logic [DIGITS-1:0]     an_o,
  output logic [6:0]            seg_o
);

  localparam int SW    = 4 * DIGITS;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // One BCD step up or down with ripple carry/borrow.
  // Returns {wrap, new_score}; wrap is the carry/borrow out of the top digit.
  function automatic logic [SW:0] bcd_step(input logic [SW-1:0] s, input logic up);
    logic [SW-1:0] res;
    logic          carry;
    logic [3:0]    dig;
    res   = s;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      dig = s[4*d +: 4];
      if (carry) begin
        if (up) begin
          if (dig == 4'd9) begin
            res[4*d +: 4] = 4'd0;
            carry         = 1'b1;
          end else begin
            res[4*d +: 4] = dig + 4'd1;
            carry         = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            res[4*d +: 4] = 4'd9;
            carry         = 1'b1;
          end else begin
            res[4*d +: 4] = dig - 4'd1;
            carry         = 1'b0;
          end
        end
      end else begin
        res[4*d +: 4] = dig;
      end
    end
    return {carry, res};
  endfunction

  // Seven-segment pattern {g..a} for a BCD digit; non-BCD values go dark.
  function automatic logic [6:0] seg_pattern(input logic [3:0] dig);
    logic [6:0] p;
    case (dig)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  logic [SW-1:0]     score_q, score_d;
  logic              wrap_q, wrap_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic [SW:0]       step_up_s, step_dn_s;
  logic [DIGITS-1:0] shown_s;
  logic              any_nz_s;
  logic [3:0]        cur_digit_s;
  logic              cur_shown_s;

  // Command decode: erase wins, inc/dec only when exactly one is asserted.
  always_comb begin
    step_up_s = bcd_step(score_q, 1'b1);
    step_dn_s = bcd_step(score_q, 1'b0);
    score_d   = score_q;
    wrap_d    = 1'b0;
    if (erase_i) begin
      score_d = {SW{1'b0}};
      wrap_d  = 1'b0;
    end else if (inc_i && !dec_i) begin
      score_d = step_up_s[SW-1:0];
      wrap_d  = step_up_s[SW];
    end else if (dec_i && !inc_i) begin
      score_d = step_dn_s[SW-1:0];
      wrap_d  = step_dn_s[SW];
    end else begin
      score_d = score_q;
      wrap_d  = 1'b0;
    end
  end

  // Scan divider and digit index.
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = {DIV_W{1'b0}};
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
    end
  end

  // Display decode: blanking scans from the top digit down; a digit is shown
  // once any digit at or above it is nonzero, and digit 0 always shows.
  always_comb begin
    any_nz_s    = 1'b0;
    shown_s     = {DIGITS{1'b0}};
    cur_digit_s = 4'd0;
    cur_shown_s = 1'b0;
    an_d        = {DIGITS{1'b0}};
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any_nz_s   = any_nz_s | (score_q[4*k +: 4] != 4'd0);
      shown_s[k] = any_nz_s | (k == 0);
    end
    for (int k = 0; k < DIGITS; k++) begin
      an_d[k]     = (idx_q == IDX_W'(k));
      cur_digit_s = (idx_q == IDX_W'(k)) ? score_q[4*k +: 4] : cur_digit_s;
      cur_shown_s = (idx_q == IDX_W'(k)) ? shown_s[k] : cur_shown_s;
    end
    seg_d = cur_shown_s ? seg_pattern(cur_digit_s) : 7'b0000000;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= {SW{1'b0}};
      wrap_q  <= 1'b0;
      div_q   <= {DIV_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      an_q    <= {DIGITS{1'b0}};
      seg_q   <= 7'b0000000;
    end else begin
      score_q <= score_d;
      wrap_q  <= wrap_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign score_o = score_q;
  assign wrap_o  = wrap_q;
  assign an_o    = an_q;
  assign seg_o   = seg_q;

endmodule

// File: tb/tb_scoreboard_display.sv
// Directed testbench for scoreboard_display: one instance with DIGITS=2,
// SCAN_DIV=4 and one with DIGITS=3, SCAN_DIV=1, sharing clock and reset.
module tb_scoreboard_display;

  logic        clk;
  logic        rst;
  logic        inc_a, dec_a, erase_a;
  logic        inc_b, dec_b, erase_b;
  logic [7:0]  score_a;
  logic        wrap_a;
  logic [1:0]  an_a;
  logic [6:0]  seg_a;
  logic [11:0] score_b;
  logic        wrap_b;
  logic [2:0]  an_b;
  logic [6:0]  seg_b;

  int n_pass  = 0;
  int n_total = 0;
  int ncyc    = 0;   // rising edges seen with reset released
  int wraps   = 0;

  scoreboard_display #(.DIGITS(2), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .inc_i(inc_a), .dec_i(dec_a), .erase_i(erase_a),
    .score_o(score_a), .wrap_o(wrap_a), .an_o(an_a), .seg_o(seg_a)
  );

  scoreboard_display #(.DIGITS(3), .SCAN_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .inc_i(inc_b), .dec_i(dec_b), .erase_i(erase_b),
    .score_o(score_b), .wrap_o(wrap_b), .an_o(an_b), .seg_o(seg_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    if (rst) ncyc++;
    #1;
  endtask

  // Expected scan index from the edge count (bench-side model).
  function automatic int idx_a();
    return ((ncyc - 1) / 4) % 2;
  endfunction
  function automatic int idx_b();
    return (ncyc - 1) % 3;
  endfunction

  task automatic cmd_a(input logic i, input logic d, input logic e);
    inc_a = i; dec_a = d; erase_a = e;
    tick();
    inc_a = 1'b0; dec_a = 1'b0; erase_a = 1'b0;
    if (wrap_a) wraps++;
  endtask

  task automatic cmd_b(input logic i, input logic d, input logic e);
    inc_b = i; dec_b = d; erase_b = e;
    tick();
    inc_b = 1'b0; dec_b = 1'b0; erase_b = 1'b0;
  endtask

  // Wait until digit k of instance A is enabled, then check its segments.
  task automatic a_digit(input int k, input logic [6:0] exp, input string tag);
    tick();
    for (int t = 0; t < 8; t++) begin
      if (idx_a() != k) tick();
    end
    check({tag, "_an"}, 32'(an_a), 32'd1 << k);
    check({tag, "_seg"}, 32'(seg_a), 32'(exp));
  endtask

  initial begin
    rst = 1'b0;
    inc_a = 1'b0; dec_a = 1'b0; erase_a = 1'b0;
    inc_b = 1'b0; dec_b = 1'b0; erase_b = 1'b0;

    // Reset state
    #2;
    check("rst_score_a", 32'(score_a), 32'h0);
    check("rst_wrap_a",  32'(wrap_a),  32'h0);
    check("rst_an_a",    32'(an_a),    32'h0);
    check("rst_seg_a",   32'(seg_a),   32'h0);
    check("rst_an_b",    32'(an_b),    32'h0);
    check("rst_seg_b",   32'(seg_b),   32'h0);
    @(posedge clk);
    #3 rst = 1'b1;

    // Idle scan: 4 cycles digit 0 (shows 0), 4 cycles digit 1 (blanked)
    for (int i = 0; i < 16; i++) begin
      tick();
      check("idle_an", 32'(an_a), (((i / 4) % 2) == 0) ? 32'h1 : 32'h2);
      check("idle_seg", 32'(seg_a), (((i / 4) % 2) == 0) ? 32'h3F : 32'h0);
    end
    check("idle_score", 32'(score_a), 32'h00);

    // Increment ripple 0 -> 10
    wraps = 0;
    for (int i = 0; i < 10; i++) cmd_a(1'b1, 1'b0, 1'b0);
    check("inc10_score", 32'(score_a), 32'h10);
    a_digit(1, 7'b0000110, "inc10_d1");
    a_digit(0, 7'b0111111, "inc10_d0");

    // Borrow ripple 10 -> 09 and back
    cmd_a(1'b0, 1'b1, 1'b0);
    check("dec_borrow", 32'(score_a), 32'h09);
    a_digit(1, 7'b0000000, "dec09_d1_blank");
    a_digit(0, 7'b1101111, "dec09_d0");
    cmd_a(1'b1, 1'b0, 1'b0);
    check("inc_back", 32'(score_a), 32'h10);

    // Up to 99 with no wrap, then wrap both ways
    for (int i = 0; i < 89; i++) cmd_a(1'b1, 1'b0, 1'b0);
    check("inc99_score", 32'(score_a), 32'h99);
    check("no_wrap_to_99", 32'(wraps), 32'd0);
    cmd_a(1'b1, 1'b0, 1'b0);
    check("wrap_up_score", 32'(score_a), 32'h00);
    check("wrap_up_pulse", 32'(wrap_a), 32'h1);
    tick();
    check("wrap_up_1cyc", 32'(wrap_a), 32'h0);
    cmd_a(1'b0, 1'b1, 1'b0);
    check("wrap_dn_score", 32'(score_a), 32'h99);
    check("wrap_dn_pulse", 32'(wrap_a), 32'h1);
    tick();
    check("wrap_dn_1cyc", 32'(wrap_a), 32'h0);

    // Simultaneous commands
    cmd_a(1'b0, 1'b0, 1'b1);
    check("erase", 32'(score_a), 32'h00);
    for (int i = 0; i < 42; i++) cmd_a(1'b1, 1'b0, 1'b0);
    check("at42", 32'(score_a), 32'h42);
    cmd_a(1'b1, 1'b1, 1'b0);
    check("incdec_hold", 32'(score_a), 32'h42);
    check("incdec_wrap", 32'(wrap_a), 32'h0);
    cmd_a(1'b1, 1'b0, 1'b1);
    check("inc_erase", 32'(score_a), 32'h00);
    cmd_a(1'b0, 1'b1, 1'b1);
    check("dec_erase", 32'(score_a), 32'h00);
    check("dec_erase_wrap", 32'(wrap_a), 32'h0);

    // Reset mid-operation at 57, between edges
    for (int i = 0; i < 57; i++) cmd_a(1'b1, 1'b0, 1'b0);
    check("at57", 32'(score_a), 32'h57);
    #2 rst = 1'b0;
    #1;
    check("midrst_score", 32'(score_a), 32'h0);
    check("midrst_wrap",  32'(wrap_a),  32'h0);
    check("midrst_an",    32'(an_a),    32'h0);
    check("midrst_seg",   32'(seg_a),   32'h0);
    #2 rst = 1'b1;
    ncyc = 0;
    tick();
    check("rel_an_a",  32'(an_a),  32'h1);
    check("rel_seg_a", 32'(seg_a), 32'h3F);
    check("rel_an_b",  32'(an_b),  32'h1);
    check("rel_seg_b", 32'(seg_b), 32'h3F);

    // DIGITS=3, SCAN_DIV=1: score 005, upper digits blanked
    for (int i = 0; i < 5; i++) cmd_b(1'b1, 1'b0, 1'b0);
    check("b_005", 32'(score_b), 32'h005);
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("b005_an", 32'(an_b), 32'd1 << idx_b());
      check("b005_seg", 32'(seg_b), (idx_b() == 0) ? 32'h6D : 32'h0);
    end

    // Score 100: all three digits shown
    for (int i = 0; i < 95; i++) cmd_b(1'b1, 1'b0, 1'b0);
    check("b_100", 32'(score_b), 32'h100);
    check("b_100_wrap", 32'(wrap_b), 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b100_an", 32'(an_b), 32'd1 << idx_b());
      check("b100_seg", 32'(seg_b), (idx_b() == 2) ? 32'h06 : 32'h3F);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
